// File: rtl/csa_tree_sched.sv
// rtl/csa_tree_sched.sv - round-robin, credit-gated issue scheduler for the CSA reduction tree
// Tracks op metadata in order and flags tree outputs that break the fixed-latency schedule.
module csa_tree_sched #(
   parameter int LATENCY = 4,
   parameter int CRED    = 4,
   parameter int TAGW    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req_valid,
   input  logic [TAGW-1:0] req_tag0,
   input  logic [TAGW-1:0] req_tag1,
   output logic [1:0]      req_ready,
   output logic            tree_v_in,
   output logic            tree_sel,
   input  logic            tree_v_out,
   output logic            buf_wr,
   output logic            buf_rd,
   output logic            res_valid,
   input  logic            res_ready,
   output logic            res_src,
   output logic [TAGW-1:0] res_tag,
   output logic            err
);

   localparam int CW = $clog2(CRED + 1);
   localparam int PW = (CRED > 1) ? $clog2(CRED) : 1;
   localparam logic [CW-1:0] CRED_C   = CW'(CRED);
   localparam logic [CW-1:0] ONE_C    = CW'(1);
   localparam logic [PW-1:0] PTR_LAST = PW'(CRED - 1);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);

   logic [CW-1:0]      credits;
   logic [CW-1:0]      buf_cnt;
   logic               rr_ptr;
   logic [LATENCY-1:0] exp_sr;
   logic [TAGW:0]      meta_mem [CRED];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic               grant_id;
   logic               issue;
   logic [TAGW-1:0]    grant_tag;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PTR_LAST) ? '0 : p + PTR_ONE;
   endfunction

   // A lone requester wins outright; rr_ptr only breaks ties.
   always_comb begin
      grant_id = rr_ptr;
      if (req_valid == 2'b01)
         grant_id = 1'b0;
      else if (req_valid == 2'b10)
         grant_id = 1'b1;
      issue     = (credits != '0) && (req_valid != 2'b00);
      req_ready = {issue & grant_id, issue & ~grant_id};
      grant_tag = grant_id ? req_tag1 : req_tag0;
   end

   assign buf_wr             = tree_v_out;
   assign res_valid          = (buf_cnt != '0);
   assign buf_rd             = res_valid & res_ready;
   assign {res_src, res_tag} = meta_mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tree_v_in <= 1'b0;
         tree_sel  <= 1'b0;
         rr_ptr    <= 1'b0;
         credits   <= CRED_C;
         buf_cnt   <= '0;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         exp_sr    <= '0;
         err       <= 1'b0;
         for (int i = 0; i < CRED; i++)
            meta_mem[i] <= '0;
      end else begin
         tree_v_in <= issue;
         if (issue) begin
            tree_sel         <= grant_id;
            rr_ptr           <= ~grant_id;
            meta_mem[wr_ptr] <= {grant_id, grant_tag};
            wr_ptr           <= ptr_next(wr_ptr);
         end
         if (buf_rd)
            rd_ptr <= ptr_next(rd_ptr);

         // Credits cover ops in the tree plus results still buffered.
         if (issue && !buf_rd)
            credits <= credits - ONE_C;
         else if (!issue && buf_rd && credits != CRED_C)
            credits <= credits + ONE_C;

         if (buf_wr && !buf_rd && buf_cnt != CRED_C)
            buf_cnt <= buf_cnt + ONE_C;
         else if (!buf_wr && buf_rd)
            buf_cnt <= buf_cnt - ONE_C;

         for (int i = LATENCY - 1; i > 0; i--)
            exp_sr[i] <= exp_sr[i-1];
         exp_sr[0] <= tree_v_in;
         if (tree_v_out != exp_sr[LATENCY-1])
            err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_csa_tree_sched.sv
// tb/tb_csa_tree_sched.sv - randomized self-checking bench for csa_tree_sched
// Emulates a fixed-latency tree and scores grants and results against an op-list model.
module tb_csa_tree_sched;

   localparam int LATENCY = 4;
   localparam int CRED    = 4;
   localparam int TAGW    = 4;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic [1:0]      req_valid = 2'b00;
   logic [TAGW-1:0] req_tag0 = '0;
   logic [TAGW-1:0] req_tag1 = '0;
   logic [1:0]      req_ready;
   logic            tree_v_in;
   logic            tree_sel;
   logic            tree_v_out = 1'b0;
   logic            buf_wr;
   logic            buf_rd;
   logic            res_valid;
   logic            res_ready = 1'b0;
   logic            res_src;
   logic [TAGW-1:0] res_tag;
   logic            err;

   csa_tree_sched #(.LATENCY(LATENCY), .CRED(CRED), .TAGW(TAGW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_tag0(req_tag0),
      .req_tag1(req_tag1), .req_ready(req_ready), .tree_v_in(tree_v_in),
      .tree_sel(tree_sel), .tree_v_out(tree_v_out), .buf_wr(buf_wr),
      .buf_rd(buf_rd), .res_valid(res_valid), .res_ready(res_ready),
      .res_src(res_src), .res_tag(res_tag), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            src;
      logic [TAGW-1:0] tag;
      int              due;
   } op_t;

   int   errors = 0;
   int   checks = 0;
   op_t  ops[$];
   logic pipe[$];
   int   edge_n = 0;
   logic rr = 1'b0;

   // Tree stand-in: whatever enters tree_v_in leaves tree_v_out LATENCY cycles later.
   task automatic tick();
      @(posedge clk);
      edge_n++;
      @(negedge clk);
      pipe.push_back(tree_v_in);
      tree_v_out = pipe.pop_front();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req_valid = 2'b00;
      res_ready = 1'b0;
      tree_v_out = 1'b0;
      pipe.delete();
      for (int i = 0; i < LATENCY; i++) pipe.push_back(1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      ops.delete();
      rr = 1'b0;
   endtask

   // One modelled cycle: inputs are already applied; issue edge N gives a result visible after edge N+LATENCY+1.
   task automatic cycle(output logic hs, output logic g);
      logic [1:0] exp_rdy;
      logic       exp_arr;
      logic       exp_rv;
      logic       pop;
      exp_rdy = 2'b00;
      g = 1'b0;
      if (ops.size() < CRED && req_valid != 2'b00) begin
         g = (req_valid == 2'b11) ? rr : req_valid[1];
         exp_rdy[g] = 1'b1;
      end
      hs = (exp_rdy != 2'b00);
      exp_rv = (ops.size() > 0) && (ops[0].due <= edge_n);
      exp_arr = 1'b0;
      foreach (ops[k]) if (ops[k].due == edge_n + 1) exp_arr = 1'b1;
      pop = exp_rv && res_ready;
      #1;
      checks++;
      if (req_ready !== exp_rdy) begin
         errors++;
         $display("FAIL req_ready: got %b expected %b", req_ready, exp_rdy);
      end
      checks++;
      if (res_valid !== exp_rv) begin
         errors++;
         $display("FAIL res_valid: got %b expected %b", res_valid, exp_rv);
      end
      checks++;
      if (tree_v_out !== exp_arr || buf_wr !== exp_arr) begin
         errors++;
         $display("FAIL arrival: tree_v_out %b buf_wr %b expected %b", tree_v_out, buf_wr, exp_arr);
      end
      checks++;
      if (buf_rd !== pop) begin
         errors++;
         $display("FAIL buf_rd: got %b expected %b", buf_rd, pop);
      end
      if (exp_rv) begin
         checks++;
         if (res_src !== ops[0].src || res_tag !== ops[0].tag) begin
            errors++;
            $display("FAIL head: src %b tag %0d expected src %b tag %0d",
                     res_src, res_tag, ops[0].src, ops[0].tag);
         end
      end
      if (pop) void'(ops.pop_front());
      if (hs) begin
         ops.push_back('{src: g, tag: (g ? req_tag1 : req_tag0), due: edge_n + LATENCY + 2});
         rr = ~g;
      end
      tick();
      #1;
      checks++;
      if (tree_v_in !== hs || (hs && tree_sel !== g)) begin
         errors++;
         $display("FAIL issue: tree_v_in %b tree_sel %b expected %b/%b", tree_v_in, tree_sel, hs, g);
      end
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_quiet: got %b expected 0", err);
      end
   endtask

   task automatic drain();
      logic hs, g;
      int   n;
      req_valid = 2'b00;
      res_ready = 1'b1;
      n = 0;
      while (ops.size() > 0 && n < 40) begin
         cycle(hs, g);
         n++;
      end
      checks++;
      if (ops.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: %0d ops left expected 0", ops.size());
      end
      res_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 2'b00;
      #1;
      checks++;
      if ({tree_v_in, tree_sel, res_valid, res_src, res_tag, err, req_ready} !== '0) begin
         errors++;
         $display("FAIL reset_state: v_in %b sel %b rv %b src %b tag %0d err %b rdy %b expected all 0",
                  tree_v_in, tree_sel, res_valid, res_src, res_tag, err, req_ready);
      end
      do_reset();
      req_valid = 2'b11;
      #1;
      checks++;
      if (req_ready !== 2'b01) begin
         errors++;
         $display("FAIL reset_rr: got %b expected 01", req_ready);
      end
      req_valid = 2'b00;
   endtask

   task automatic test_single();
      logic hs, g;
      do_reset();
      req_valid = 2'b01;
      req_tag0 = 4'd3;
      cycle(hs, g);
      req_valid = 2'b00;
      res_ready = 1'b1;
      for (int i = 0; i < 8; i++) cycle(hs, g);
      req_valid = 2'b01;
      res_ready = 1'b0;
      for (int i = 0; i < CRED; i++) begin
         req_tag0 = TAGW'(i);
         cycle(hs, g);
         checks++;
         if (hs !== 1'b1) begin
            errors++;
            $display("FAIL credits_restored: issue %0d got %b expected 1", i, hs);
         end
      end
      drain();
   endtask

   task automatic test_contention();
      logic hs, g;
      int   ng;
      do_reset();
      req_valid = 2'b11;
      res_ready = 1'b1;
      ng = 0;
      for (int i = 0; i < 20; i++) begin
         req_tag0 = TAGW'($urandom);
         req_tag1 = TAGW'($urandom);
         cycle(hs, g);
         if (hs) begin
            checks++;
            if (g !== ng[0]) begin
               errors++;
               $display("FAIL alternate: grant %0d got %b expected %b", ng, g, ng[0]);
            end
            ng++;
         end
      end
      drain();
   endtask

   task automatic test_credit_stall();
      logic hs, g;
      int   n;
      do_reset();
      req_valid = 2'b01;
      res_ready = 1'b0;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         req_tag0 = TAGW'(i);
         cycle(hs, g);
         if (hs) n++;
      end
      checks++;
      if (n != CRED) begin
         errors++;
         $display("FAIL stall_count: got %0d issues expected %0d", n, CRED);
      end
      res_ready = 1'b1;
      cycle(hs, g);
      checks++;
      if (hs !== 1'b0) begin
         errors++;
         $display("FAIL stall_pop_cycle: issue got %b expected 0", hs);
      end
      res_ready = 1'b0;
      cycle(hs, g);
      checks++;
      if (hs !== 1'b1) begin
         errors++;
         $display("FAIL stall_resume: issue got %b expected 1", hs);
      end
      cycle(hs, g);
      checks++;
      if (hs !== 1'b0) begin
         errors++;
         $display("FAIL stall_again: issue got %b expected 0", hs);
      end
      drain();
   endtask

   task automatic test_issue_pop_cred1();
      logic hs, g;
      int   n;
      do_reset();
      req_valid = 2'b01;
      res_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         req_tag0 = TAGW'(i);
         cycle(hs, g);
      end
      req_valid = 2'b00;
      n = 0;
      while (!(ops.size() > 0 && ops[0].due <= edge_n) && n < 20) begin
         cycle(hs, g);
         n++;
      end
      req_valid = 2'b01;
      req_tag0 = 4'd4;
      res_ready = 1'b1;
      cycle(hs, g);
      checks++;
      if (hs !== 1'b1) begin
         errors++;
         $display("FAIL cred1_issue_pop: issue got %b expected 1", hs);
      end
      req_tag0 = 4'd5;
      res_ready = 1'b0;
      cycle(hs, g);
      checks++;
      if (hs !== 1'b1) begin
         errors++;
         $display("FAIL cred1_held: issue got %b expected 1", hs);
      end
      req_tag0 = 4'd6;
      cycle(hs, g);
      checks++;
      if (hs !== 1'b0) begin
         errors++;
         $display("FAIL cred1_full: issue got %b expected 0", hs);
      end
      drain();
   endtask

   task automatic test_random();
      logic hs, g;
      do_reset();
      for (int i = 0; i < 300; i++) begin
         req_valid = 2'($urandom_range(0, 3));
         req_tag0 = TAGW'($urandom);
         req_tag1 = TAGW'($urandom);
         res_ready = ($urandom_range(0, 3) != 0);
         cycle(hs, g);
      end
      drain();
   endtask

   task automatic test_protocol_err();
      do_reset();
      #1;
      checks++;
      if (err !== 1'b0) begin
         errors++;
         $display("FAIL err_clear: got %b expected 0", err);
      end
      tree_v_out = 1'b1;
      tick();
      #1;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_set: got %b expected 1", err);
      end
      for (int i = 0; i < 3; i++) tick();
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL err_sticky: got %b expected 1", err);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (err !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL err_reset: err %b res_valid %b expected 0 0", err, res_valid);
      end
      do_reset();
   endtask

   task automatic test_reset_midflight();
      logic hs, g;
      do_reset();
      req_valid = 2'b01;
      for (int i = 0; i < 3; i++) begin
         req_tag0 = TAGW'(i + 7);
         cycle(hs, g);
      end
      req_valid = 2'b00;
      rst_n = 1'b0;
      #1;
      checks++;
      if (tree_v_in !== 1'b0 || res_valid !== 1'b0) begin
         errors++;
         $display("FAIL midflight_reset: tree_v_in %b res_valid %b expected 0 0", tree_v_in, res_valid);
      end
      tick();
      rst_n = 1'b1;
      ops.delete();
      req_valid = 2'b01;
      res_ready = 1'b0;
      for (int i = 0; i < CRED + 1; i++) begin
         logic [1:0] want;
         want = (i < CRED) ? 2'b01 : 2'b00;
         #1;
         checks++;
         if (req_ready !== want) begin
            errors++;
            $display("FAIL midflight_credits: cycle %0d got %b expected %b", i, req_ready, want);
         end
         tick();
      end
      req_valid = 2'b00;
      tick();
      #1;
      checks++;
      if (err !== 1'b1) begin
         errors++;
         $display("FAIL stale_err: got %b expected 1", err);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_contention();
      test_credit_stall();
      test_issue_pop_cred1();
      test_random();
      test_protocol_err();
      test_reset_midflight();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
